// File: rtl/truth_table_checker.sv
// Sweeps all 16 input vectors of a 4-input logic function, lets each settle,
// samples f_in and compares it against a latched expected truth table.
module truth_table_checker #(
  parameter int SETTLE_CYCLES = 4  // legal range 1..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        f_in,
  output logic [3:0]  x_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] mismatch,
  output logic [4:0]  err_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_e      state_q;
  logic [15:0] exp_q;
  logic [7:0]  cnt_q;
  logic [3:0]  x_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic [15:0] mis_q;
  logic [4:0]  err_q;

  logic        bit_mis_d;
  logic [4:0]  err_d;

  // NOTE: every signal driven in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    bit_mis_d = f_in ^ exp_q[x_q];
    err_d     = err_q + 5'(bit_mis_d);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge value of every other register, whatever the order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      exp_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mis_q   <= '0;
      err_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            exp_q   <= expected;
            x_q     <= '0;
            cnt_q   <= '0;
            mis_q   <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        SAMPLE: begin
          mis_q[x_q] <= bit_mis_d;
          err_q      <= err_d;
          // pass is judged on the count including this final sample
          if (x_q == 4'd15) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 5'd0);
            state_q <= DONE;
          end else begin
            x_q     <= x_q + 4'd1;
            cnt_q   <= '0;
            state_q <= SETTLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign x_out     = x_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign mismatch  = mis_q;
  assign err_count = err_q;

endmodule

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, sets cycles each input vector is held before f_in is sampled; legal range 1..255.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse that begins a 16-vector sweep.
REQ-005 expected  input  16  expected truth table; bit i = required f for input vector i.
REQ-006 f_in  input  1  output of the 4-input logic function under check.
REQ-007 x_out  output  4  applied input vector; x1=bit0, x2=bit1, x3=bit2, x4=bit3.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  high from sweep completion until the next start or reset.
REQ-010 pass  output  1  high when done=1 and err_count=0.
REQ-011 mismatch  output  16  bit i set when f_in differed from expected[i] at vector i.
REQ-012 err_count  output  5  number of mismatching vectors, 0..16.

Function
REQ-013 FSM states: IDLE, SETTLE, SAMPLE, DONE; busy=1 in SETTLE and SAMPLE only.
REQ-014 IDLE or DONE with start=1: latch expected, index=0, x_out=0, settle counter=0, clear mismatch and err_count, clear done, go to SETTLE.
REQ-015 start while busy is ignored; the latched expected value does not change mid-sweep.
REQ-016 SETTLE: counter increments each cycle; at counter=SETTLE_CYCLES-1, go to SAMPLE.
REQ-017 SAMPLE: mismatch[index] <= f_in XOR expected_latched[index]; err_count increments by 1 on a mismatch.
REQ-018 SAMPLE with index<15: index and x_out increment, counter=0, return to SETTLE; with index=15: go to DONE, x_out holds 15.
REQ-019 Each vector occupies exactly SETTLE_CYCLES+1 cycles; a full sweep takes 16*(SETTLE_CYCLES+1) cycles from the start edge to the done assertion.
REQ-020 x_out changes only at sweep start and on SAMPLE-to-SETTLE transitions; it is stable for every sampled cycle.
REQ-021 err_count saturates naturally at 16; it does not wrap, and 5 bits suffice.
REQ-022 DONE holds mismatch, err_count, done=1 and pass until start or rst.

Reset
REQ-023 rst=1 forces the following immediately, independent of clk, including mid-sweep: state=IDLE, x_out=0, busy=0, done=0, pass=0, mismatch=0, err_count=0, index=0, counter=0.
REQ-024 While rst=1, start is ignored; the first start after rst deasserts begins a normal sweep.

Verification
REQ-025 Connect f_in to a model of f = x1x3 + x2x4 + (x1+~x3)(~x2+x4); set expected=16'hEFA3, SETTLE_CYCLES=4, pulse start -> done after 80 cycles, pass=1, mismatch=0, err_count=0.
REQ-026 Tie f_in=0 and set expected=16'hEFA3 -> mismatch=16'hEFA3, err_count=11, pass=0.
REQ-027 Use the same model with f_in inverted only when x_out=5 -> mismatch=16'h0020, err_count=1, pass=0.
REQ-028 Pulse start again at vector 3 of a sweep -> ignored, sweep completes on its original schedule; pulse start in DONE -> results clear, new sweep begins, done=0.
REQ-029 Assert rst asynchronously between clock edges while x_out=7 -> all outputs are 0 before the next edge, state=IDLE; a later start yields the result of REQ-025.
REQ-030 SETTLE_CYCLES=1 -> each vector lasts 2 cycles, sweep completes in 32 cycles, and x_out steps 0..15 in order.
